// File: rtl/ram_burst_ctrl_if.sv
// ram_burst_ctrl_if
//   Bundles the command, write-stream, read-stream, status and RAM pin
//   signals of the burst controller.
//   Modports:
//     slave  - the controller: takes commands and write beats, produces read
//              beats and status, drives the RAM pins, receives RAM Q.
//     master - the bus master and RAM side: issues commands, streams write
//              data, consumes read data and returns RAM Q.
interface ram_burst_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 24,
  parameter int LW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_a;
  logic          ram_we;
  logic          ram_oe;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, ram_q,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output busy, done, ram_a, ram_we, ram_oe, ram_d
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, ram_q,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  busy, done, ram_a, ram_we, ram_oe, ram_d
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
//   Burst controller in front of a single-port synchronous RAM (address
//   registered on CK, Q valid one cycle later). One burst command is handled
//   at a time. Write beats go straight to the RAM on the handshake edge; read
//   beats are fetched ahead into a 2-entry buffer so that read backpressure
//   never loses data.
//   Ports:
//     CK    - clock, rising edge
//     RST_N - asynchronous active-low reset
//     bus   - ram_burst_ctrl_if.slave: command, write/read streams, busy/done
//             status and the RAM A/WE/OE/D/Q pins
module ram_burst_ctrl #(
  parameter int AW = 16,
  parameter int DW = 24,
  parameter int LW = 8
) (
  input logic              CK,
  input logic              RST_N,
  ram_burst_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] last_a;
  logic [LW:0]   beats_left;
  logic [LW:0]   issue_left;
  logic          inflight;
  logic [DW-1:0] buf_mem [2];
  logic          head;
  logic [1:0]    count;
  logic          cmd_ready_q;
  logic          done_q;

  logic          wr_fire;
  logic          pop;
  logic          issue;
  logic [1:0]    credit_used;

  assign wr_fire = (state == WRITE) && bus.wr_valid;
  assign pop     = (count != 2'd0) && bus.rd_ready;

  // A beat being popped this cycle frees its slot at the same edge, which
  // is what lets a read burst stream at one beat per cycle.
  assign credit_used = count + {1'b0, inflight} - {1'b0, pop};
  assign issue       = (state == READ) && (issue_left != '0) && (credit_used < 2'd2);

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_ready  = (state == WRITE);
  assign bus.ram_we    = wr_fire;
  assign bus.ram_d     = (state == WRITE) ? bus.wr_data : '0;
  // The address follows the burst only while writing or issuing a read;
  // otherwise the last address driven to the RAM is held.
  assign bus.ram_a     = ((state == WRITE) || issue) ? cur_addr : last_a;
  assign bus.ram_oe    = (state == READ) || ((state == DRAIN) && inflight);
  assign bus.rd_valid  = (count != 2'd0);
  assign bus.rd_data   = buf_mem[head];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cur_addr    <= '0;
      last_a      <= '0;
      beats_left  <= '0;
      issue_left  <= '0;
      inflight    <= 1'b0;
      buf_mem[0]  <= '0;
      buf_mem[1]  <= '0;
      head        <= 1'b0;
      count       <= 2'd0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;

      // RAM Q is valid the cycle after an issue; the slot after the current
      // head (or the head itself when empty) receives it.
      if (inflight) begin
        buf_mem[head ^ count[0]] <= bus.ram_q;
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
      if (pop) begin
        head <= ~head;
      end

      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cur_addr    <= bus.cmd_addr;
            beats_left  <= {1'b0, bus.cmd_len} + (LW+1)'(1);
            issue_left  <= {1'b0, bus.cmd_len} + (LW+1)'(1);
            cmd_ready_q <= 1'b0;
            state       <= bus.cmd_write ? WRITE : READ;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        WRITE: begin
          if (bus.wr_valid) begin
            last_a     <= cur_addr;
            cur_addr   <= cur_addr + AW'(1);
            beats_left <= beats_left - (LW+1)'(1);
            if (beats_left == (LW+1)'(1)) begin
              state       <= IDLE;
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
            end
          end
        end

        READ: begin
          if (issue) begin
            last_a     <= cur_addr;
            cur_addr   <= cur_addr + AW'(1);
            issue_left <= issue_left - (LW+1)'(1);
            if (issue_left == (LW+1)'(1)) begin
              state <= DRAIN;
            end
          end
          // The final beat cannot be popped here: it is issued in READ and
          // only reaches the buffer after the move to DRAIN.
          if (pop) begin
            beats_left <= beats_left - (LW+1)'(1);
          end
        end

        DRAIN: begin
          if (pop) begin
            beats_left <= beats_left - (LW+1)'(1);
            if (beats_left == (LW+1)'(1)) begin
              state       <= IDLE;
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl
//   Directed bench for ram_burst_ctrl. A table of burst vectors is applied
//   in a loop against a behavioural RAM; hand-written sequences cover
//   command blocking while busy and reset in the middle of a burst.
module tb_ram_burst_ctrl;

  logic CK;
  logic RST_N;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  ram_burst_ctrl_if #(.AW(16), .DW(24), .LW(8)) bus ();

  ram_burst_ctrl #(.AW(16), .DW(24), .LW(8)) dut (
    .CK    (CK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // Behavioural 64K x 24 RAM: writes on WE, address registered on CK with
  // Q valid the following cycle.
  logic [23:0] mem    [0:65535];
  logic [23:0] shadow [0:65535];

  always @(posedge CK) begin
    if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;
    if (bus.ram_oe) bus.ram_q <= mem[bus.ram_a];
  end

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  always @(posedge CK) cyc <= cyc + 1;

  typedef struct {
    bit          is_write;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [23:0] first_data;
    logic [23:0] last_data;
    logic [3:0]  rdy_pat;
    bit          gap;
    bit          chk_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issueCmd(input bit wr, input logic [15:0] a, input logic [7:0] l, output int acc_cyc);
    bit accepted;
    accepted = 1'b0;
    acc_cyc  = -1;
    @(negedge CK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    for (int t = 0; t < 100 && !accepted; t++) begin
      if (bus.cmd_ready) begin
        acc_cyc  = cyc + 1;
        accepted = 1'b1;
      end
      @(negedge CK);
    end
    bus.cmd_valid = 1'b0;
    checkOutput("cmd_accept", 64'(accepted), 64'(1));
  endtask

  task automatic driveWriteBeats(input logic [15:0] a, input logic [7:0] l,
                                 input logic [23:0] first, input logic [23:0] last,
                                 input bit gap, input int nbeats);
    logic [23:0] d;
    for (int k = 0; k < nbeats; k++) begin
      d = (k == int'(l)) ? last : first + 24'(k);
      if (gap && k == 1) begin
        bus.wr_valid = 1'b0;
        #1;
        checkOutput("wr_gap", 64'({bus.ram_we, bus.busy}), 64'(2'b01));
        @(negedge CK);
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      #1;
      checkOutput("wr_beat", 64'({bus.wr_ready, bus.ram_we, bus.ram_a, bus.ram_d}),
                  64'({1'b1, 1'b1, a + 16'(k), d}));
      shadow[a + 16'(k)] = d;
      @(negedge CK);
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic collectRead(input logic [15:0] a, input logic [7:0] l, input logic [3:0] pat,
                             input int acc_cyc, input bit chk_lat,
                             output logic [23:0] first_got, output logic [23:0] last_got);
    int k;
    int i;
    bit seen;
    bit prev_valid;
    bit prev_pop;
    k = 0; i = 0; seen = 0; prev_valid = 0; prev_pop = 0;
    first_got = '0;
    last_got  = '0;
    while (k <= int'(l) && i < 2000) begin
      bus.rd_ready = pat[2'(i % 4)];
      #1;
      if (prev_valid && !prev_pop)
        checkOutput("rd_valid_hold", 64'(bus.rd_valid), 64'(1));
      if (bus.rd_valid && !seen) begin
        seen = 1'b1;
        if (chk_lat) checkOutput("rd_latency", 64'(cyc - acc_cyc), 64'(2));
      end
      if (bus.rd_valid) begin
        checkOutput("rd_head", 64'(bus.rd_data), 64'(shadow[a + 16'(k)]));
        if (bus.rd_ready) begin
          if (k == 0) first_got = bus.rd_data;
          last_got = bus.rd_data;
          k++;
        end
      end
      prev_valid = bus.rd_valid;
      prev_pop   = bus.rd_valid && bus.rd_ready;
      i++;
      @(negedge CK);
    end
    bus.rd_ready = 1'b0;
    #1;
    checkOutput("rd_all_beats", 64'(k), 64'(int'(l) + 1));
    checkOutput("rd_done", 64'({bus.done, bus.busy, bus.cmd_ready, bus.rd_valid}), 64'(4'b1010));
  endtask

  task automatic applyStimulus(input vec_t v);
    int acc;
    logic [23:0] f;
    logic [23:0] l;
    if (v.is_write) begin
      issueCmd(1'b1, v.addr, v.len, acc);
      driveWriteBeats(v.addr, v.len, v.first_data, v.last_data, v.gap, int'(v.len) + 1);
      #1;
      checkOutput("wr_done", 64'({bus.done, bus.busy, bus.cmd_ready, bus.ram_we}), 64'(4'b1010));
    end else begin
      issueCmd(1'b0, v.addr, v.len, acc);
      collectRead(v.addr, v.len, v.rdy_pat, acc, v.chk_lat, f, l);
      checkOutput("rd_first", 64'(f), 64'(v.first_data));
      checkOutput("rd_last", 64'(l), 64'(v.last_data));
    end
    @(negedge CK);
    #1;
    checkOutput("done_single_pulse", 64'(bus.done), 64'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int acc2;
    logic [23:0] f;
    logic [23:0] l;
    vec_t rv;

    vecs[0] = '{1'b1, 16'h0010, 8'd3, 24'h000001, 24'h000004, 4'b1111, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h0010, 8'd3, 24'h000001, 24'h000004, 4'b1111, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 16'h0020, 8'd7, 24'h000A00, 24'h000A07, 4'b1111, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'h0020, 8'd7, 24'h000A00, 24'h000A07, 4'b1001, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'hFFFF, 8'd1, 24'hABCDEF, 24'h123456, 4'b1111, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 8'd0, 24'h123456, 24'h123456, 4'b1111, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 16'hFFFF, 8'd1, 24'hABCDEF, 24'h123456, 4'b1111, 1'b0, 1'b1};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #2;
    checkOutput("reset_state",
                64'({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done,
                     bus.ram_we, bus.ram_oe, bus.ram_a, bus.ram_d}), 64'(0));
    repeat (2) @(negedge CK);
    RST_N = 1'b1;
    #1;
    checkOutput("cmd_ready_before_edge", 64'(bus.cmd_ready), 64'(0));
    @(negedge CK);
    #1;
    checkOutput("cmd_ready_after_edge", 64'(bus.cmd_ready), 64'(1));

    for (int n = 0; n < 7; n++) applyStimulus(vecs[n]);

    // Command held while a read burst is stalled: blocked until done.
    bus.rd_ready = 1'b0;
    issueCmd(1'b0, 16'h0010, 8'd1, acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 16'h0000;
    bus.cmd_len   = 8'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("cmd_blocked_busy", 64'({bus.cmd_ready, bus.busy}), 64'(2'b01));
      @(negedge CK);
    end
    collectRead(16'h0010, 8'd1, 4'b1111, acc, 1'b0, f, l);
    checkOutput("blocked_read_data", 64'({f, l}), 64'({24'h000001, 24'h000002}));
    acc2 = cyc + 1;
    @(negedge CK);
    bus.cmd_valid = 1'b0;
    #1;
    checkOutput("held_cmd_accepted", 64'({bus.busy, bus.done, bus.cmd_ready}), 64'(3'b100));
    collectRead(16'h0000, 8'd0, 4'b1111, acc2, 1'b1, f, l);
    checkOutput("held_cmd_data", 64'(f), 64'(24'h123456));
    @(negedge CK);

    // Reset after five beats of a sixteen-beat write.
    issueCmd(1'b1, 16'h0100, 8'd15, acc);
    driveWriteBeats(16'h0100, 8'd15, 24'h500000, 24'h50000F, 1'b0, 5);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 24'h500005;
    #1;
    checkOutput("pre_reset_we", 64'({bus.ram_we, bus.ram_a}), 64'({1'b1, 16'h0105}));
    #1 RST_N = 1'b0;
    #1;
    checkOutput("reset_abort",
                64'({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done,
                     bus.ram_we, bus.ram_oe, bus.ram_a, bus.ram_d}), 64'(0));
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CK);
      checkOutput("no_done_in_reset", 64'(bus.done), 64'(0));
    end
    RST_N = 1'b1;
    @(negedge CK);
    #1;
    checkOutput("post_reset_idle", 64'({bus.done, bus.busy, bus.cmd_ready}), 64'(3'b001));
    rv = '{1'b0, 16'h0100, 8'd0, 24'h500000, 24'h500000, 4'b1111, 1'b0, 1'b1};
    applyStimulus(rv);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Burst memory controller that sits directly upstream of the 64K x 24 single-port system RAM. It accepts one burst command at a time from a bus master and drives the RAM address, write-enable, output-enable and write-data pins. Write data is streamed in and read data is streamed out, both with valid/ready handshakes. It hides the RAM's one-cycle read latency (the RAM registers the address on CK; Q is valid the following cycle) behind a 2-entry read buffer, so read backpressure never loses data.

Parameters:
AW, 16, address width; matches RAM A.
DW, 24, data width; matches RAM D/Q.
LW, 8, burst length field width; a burst is cmd_len+1 beats (1..256).

Ports:
CK  input  1  clock; all state changes on rising edge.
RST_N  input  1  asynchronous active-low reset.
cmd_valid  input  1  command request.
cmd_ready  output  1  controller idle and able to accept a command.
cmd_write  input  1  1 = write burst, 0 = read burst.
cmd_addr  input  AW  start address.
cmd_len  input  LW  beats minus one.
wr_valid  input  1  write beat valid.
wr_ready  output  1  write beat accepted.
wr_data  input  DW  write beat data.
rd_valid  output  1  read beat valid.
rd_ready  input  1  read beat consumed.
rd_data  output  DW  read beat data.
busy  output  1  burst in progress (state != IDLE).
done  output  1  one-cycle pulse after the final beat of a burst completes.
ram_a  output  AW  to RAM A.
ram_we  output  1  to RAM WE.
ram_oe  output  1  to RAM OE.
ram_d  output  DW  to RAM D.
ram_q  input  DW  from RAM Q.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; beat counter, address and buffer cleared; all outputs 0 (cmd_ready, wr_ready, rd_valid, busy, done, ram_we, ram_oe, ram_a, ram_d). cmd_ready goes 1 on the first edge after reset release.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. A command is accepted on cmd_valid&cmd_ready. The controller latches addr and len, beats_left=len+1, and moves to WRITE or READ according to cmd_write. cmd_ready=0 in every non-IDLE state. Commands presented while busy are not accepted.
- WRITE: wr_ready=1. Combinationally, ram_we=wr_valid, ram_a=cur_addr, ram_d=wr_data, so the RAM writes on the same edge as the handshake (zero latency). Each accepted beat: cur_addr+1, beats_left-1. Gaps in wr_valid stall the burst and hold ram_we=0. When the last beat is accepted, go to IDLE and pulse done=1 in the next cycle.
- READ: ram_oe=1. Issue: ram_a=cur_addr at an edge when (buffer occupancy + inflight) < 2 and issued < len+1; inflight=1 for exactly one cycle after each issue. On the cycle after an issue, ram_q is pushed into the buffer. rd_valid=buffer non-empty and rd_data=buffer head; a pop occurs on rd_valid&rd_ready. Push and pop in the same cycle are both legal. When all beats are issued, go to DRAIN.
- DRAIN: ram_oe=1 until inflight=0; when the last beat is popped, go to IDLE and pulse done=1 next cycle.
- Sustained rate: 1 beat/cycle when rd_ready is held high. The first rd_valid appears 2 cycles after command accept.
- Address wrap: 16'hFFFF+1 = 16'h0000 with no error; the burst continues.
- ram_a holds its last value when not issuing. ram_we=0 outside WRITE.
- Buffer overflow is impossible by the credit rule. rd_valid never deasserts before a pop.
- Reset mid-burst aborts the burst immediately: ram_we drops asynchronously, buffered read data is discarded, and no done pulse is produced.
- A length of 0 is a single beat.

Test Plan:
1. Write burst addr=16'h0010, len=3, data 24'h000001..24'h000004, wr_valid continuous -> 4 consecutive ram_we cycles at 0x0010..0x0013; done pulses once; cmd_ready returns 1.
2. Read back the same range with rd_ready=1 -> rd_data 1,2,3,4 on 4 consecutive cycles; first rd_valid 2 cycles after accept.
3. Read len=7 with rd_ready toggling 1,0,0,1 -> all 8 beats delivered in order with none dropped or duplicated; occupancy never exceeds 2.
4. Write len=1 at addr=16'hFFFF, data 24'hABCDEF/24'h123456 -> writes land at 0xFFFF and 0x0000; readback of 0x0000 gives 24'h123456.
5. Command issued while a read burst is in progress -> cmd_ready=0 and the command is ignored; it is accepted in the first IDLE cycle after done.
6. RST_N asserted in the middle of a len=15 write after 5 beats -> outputs go 0 immediately and no done pulse is produced; after release, a new len=0 read completes normally.
